// File: rtl/contador_pkg.sv
// Shared defaults and FSM encoding for the FIFO push-counter read path.
// Used by the poller, the counter block and the probador.
package contador_pkg;

   localparam int NUM_FIFOS_D = 5;
   localparam int CNT_W_D     = 5;
   localparam int IDX_W_D     = 3;
   localparam int TOT_W_D     = 8;
   localparam int TIMEOUT_D   = 15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_NEXT,
      ST_DONE
   } lector_st_e;

   function automatic int tmr_bits(input int t);
      return (t < 1) ? 1 : $clog2(t + 1);
   endfunction

endpackage

// File: rtl/lector_contador.sv
// Counter poller: sweeps every FIFO index, requests its push count,
// latches the replies and sums them; flags indices that never answer.
module lector_contador
   import contador_pkg::*;
#(
   parameter int NUM_FIFOS = NUM_FIFOS_D,
   parameter int CNT_W     = CNT_W_D,
   parameter int IDX_W     = IDX_W_D,
   parameter int TOT_W     = TOT_W_D,
   parameter int TIMEOUT   = TIMEOUT_D
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] data,
   input  logic             valid,
   output logic             req,
   output logic [IDX_W-1:0] idx,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt2,
   output logic [CNT_W-1:0] cnt3,
   output logic [CNT_W-1:0] cnt4,
   output logic [TOT_W-1:0] total,
   output logic             busy,
   output logic             done,
   output logic             error
);

   localparam int SLOTS = (NUM_FIFOS > 5) ? NUM_FIFOS : 5;
   localparam int TMR_W = tmr_bits(TIMEOUT);

   localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_FIFOS - 1);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

   lector_st_e       state_q;
   logic [TMR_W-1:0] tmr_q;
   logic [CNT_W-1:0] cnt_q [SLOTS];

   assign cnt0 = cnt_q[0];
   assign cnt1 = cnt_q[1];
   assign cnt2 = cnt_q[2];
   assign cnt3 = cnt_q[3];
   assign cnt4 = cnt_q[4];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         req     <= 1'b0;
         idx     <= '0;
         total   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         error   <= 1'b0;
         for (int i = 0; i < SLOTS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         req  <= 1'b0;
         done <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_ISSUE;
                  req     <= 1'b1;
                  idx     <= '0;
                  total   <= '0;
                  error   <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            ST_ISSUE: begin
               state_q <= ST_WAIT;
               tmr_q   <= '0;
            end
            // Only this state listens to valid; a stray one elsewhere is dropped.
            ST_WAIT: begin
               if (valid) begin
                  for (int i = 0; i < NUM_FIFOS; i++) begin
                     if (idx == IDX_W'(i)) begin
                        cnt_q[i] <= data;
                     end
                  end
                  total   <= total + TOT_W'(data);
                  state_q <= ST_NEXT;
               end else if (tmr_q == TMR_MAX) begin
                  for (int i = 0; i < NUM_FIFOS; i++) begin
                     if (idx == IDX_W'(i)) begin
                        cnt_q[i] <= '0;
                     end
                  end
                  error   <= 1'b1;
                  state_q <= ST_NEXT;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            ST_NEXT: begin
               if (idx == LAST) begin
                  state_q <= ST_DONE;
                  done    <= 1'b1;
                  busy    <= 1'b0;
               end else begin
                  state_q <= ST_ISSUE;
                  idx     <= idx + 1'b1;
                  req     <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lector_contador.sv
// Directed bench for the counter poller with a behavioural
// counter-block responder and a passive request monitor.
module tb_lector_contador;
   import contador_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       valid;
   logic [4:0] data;
   logic       req;
   logic [2:0] idx;
   logic [4:0] cnt0, cnt1, cnt2, cnt3, cnt4;
   logic [7:0] total;
   logic       busy, done, error;

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int done_count = 0;
   int idx_bad = 0;
   int err_cyc = -1;
   int last_req_idx = 0;
   int req_idx [$];
   int req_cyc [$];
   logic err_prev = 1'b0;

   int         resp_lat  = 1;
   logic [4:0] resp_mask = 5'b11111;
   logic [4:0] mem [5];
   logic       resp_valid;
   logic [4:0] resp_data;
   int         resp_k;
   logic       spur_idle  = 1'b0;
   logic       spur_issue = 1'b0;

   logic [4:0] cnt_v [5];
   assign cnt_v[0] = cnt0;
   assign cnt_v[1] = cnt1;
   assign cnt_v[2] = cnt2;
   assign cnt_v[3] = cnt3;
   assign cnt_v[4] = cnt4;

   assign valid = resp_valid | spur_idle | (spur_issue & req);
   assign data  = resp_valid ? resp_data : 5'd9;

   lector_contador dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .data  (data),
      .valid (valid),
      .req   (req),
      .idx   (idx),
      .cnt0  (cnt0),
      .cnt1  (cnt1),
      .cnt2  (cnt2),
      .cnt3  (cnt3),
      .cnt4  (cnt4),
      .total (total),
      .busy  (busy),
      .done  (done),
      .error (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (req === 1'b1) begin
         req_idx.push_back(int'(idx));
         req_cyc.push_back(cyc);
         last_req_idx = int'(idx);
      end else if (busy === 1'b1 && int'(idx) != last_req_idx) begin
         idx_bad++;
      end
      if (done === 1'b1) done_count++;
      if (error === 1'b1 && err_prev !== 1'b1) err_cyc = cyc;
      err_prev = error;
   end

   // Counter block model: answers a req resp_lat cycles later.
   initial begin
      resp_valid = 1'b0;
      resp_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (req === 1'b1 && resp_mask[idx] === 1'b1) begin
            resp_k = int'(idx);
            repeat (resp_lat) @(posedge clk);
            #1;
            resp_valid = 1'b1;
            resp_data  = mem[resp_k];
            @(posedge clk);
            #1;
            resp_valid = 1'b0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, want finish by 100us");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_sweep(output int s_cyc, output int d_cyc);
      start = 1'b1;
      tick();
      start = 1'b0;
      s_cyc = cyc;
      d_cyc = -1;
      for (int i = 0; i < 200; i++) begin
         if (done === 1'b1) begin
            d_cyc = cyc;
            break;
         end
         tick();
      end
      checks++;
      if (d_cyc < 0) begin
         errors++;
         $display("FAIL sweep_done: got no done, want done within 200");
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      tick();
      tick();
      checks++;
      if ({req, busy, done, error} !== 4'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b want 0000",
                  {req, busy, done, error});
      end
      checks++;
      if (idx !== 3'd0 || total !== 8'd0) begin
         errors++;
         $display("FAIL reset_idx_total: got %0d/%0d want 0/0",
                  idx, total);
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (cnt_v[k] !== 5'd0) begin
            errors++;
            $display("FAIL reset_cnt%0d: got %0d want 0", k, cnt_v[k]);
         end
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_normal();
      int s, d, n0;
      logic [4:0] exp [5];
      exp = '{5'd3, 5'd0, 5'd7, 5'd31, 5'd1};
      mem = exp;
      resp_lat  = 1;
      resp_mask = 5'b11111;
      n0 = req_idx.size();
      run_sweep(s, d);
      // done occupies the 16th cycle after the start edge
      checks++;
      if (d - s != 15) begin
         errors++;
         $display("FAIL normal_latency: got %0d want 15", d - s);
      end
      tick();
      tick();
      checks++;
      if (req_idx.size() - n0 != 5) begin
         errors++;
         $display("FAIL normal_reqs: got %0d want 5", req_idx.size() - n0);
      end
      for (int k = 0; k < 5; k++) begin
         if (req_idx.size() > n0 + k) begin
            checks++;
            if (req_idx[n0+k] != k || req_cyc[n0+k] - s != 3 * k) begin
               errors++;
               $display("FAIL normal_req%0d: got idx %0d at +%0d want %0d at +%0d",
                        k, req_idx[n0+k], req_cyc[n0+k] - s, k, 3 * k);
            end
         end
         checks++;
         if (cnt_v[k] !== exp[k]) begin
            errors++;
            $display("FAIL normal_cnt%0d: got %0d want %0d", k, cnt_v[k], exp[k]);
         end
      end
      checks++;
      if (total !== 8'd42 || error !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL normal_total: got %0d err %b busy %b want 42 0 0",
                  total, error, busy);
      end
   endtask

   task automatic test_slow();
      int s, d, n0, b0;
      logic [4:0] exp [5];
      exp = '{5'd17, 5'd2, 5'd30, 5'd5, 5'd9};
      mem = exp;
      resp_lat = 4;
      n0 = req_idx.size();
      b0 = idx_bad;
      run_sweep(s, d);
      checks++;
      if (d - s != 30) begin
         errors++;
         $display("FAIL slow_latency: got %0d want 30", d - s);
      end
      tick();
      tick();
      checks++;
      if (idx_bad != b0 || req_idx.size() - n0 != 5) begin
         errors++;
         $display("FAIL slow_idx_stable: got %0d moves %0d reqs want 0 5",
                  idx_bad - b0, req_idx.size() - n0);
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (cnt_v[k] !== exp[k]) begin
            errors++;
            $display("FAIL slow_cnt%0d: got %0d want %0d", k, cnt_v[k], exp[k]);
         end
      end
      checks++;
      if (total !== 8'd63 || error !== 1'b0) begin
         errors++;
         $display("FAIL slow_total: got %0d err %b want 63 0", total, error);
      end
      resp_lat = 1;
   endtask

   task automatic test_timeout();
      int s, d, n0;
      logic [4:0] exp [5];
      mem = '{5'd3, 5'd0, 5'd7, 5'd31, 5'd1};
      exp = '{5'd3, 5'd0, 5'd0, 5'd31, 5'd1};
      resp_lat  = 1;
      resp_mask = 5'b11011;
      n0 = req_idx.size();
      run_sweep(s, d);
      checks++;
      if (d - s != 30) begin
         errors++;
         $display("FAIL timeout_latency: got %0d want 30", d - s);
      end
      tick();
      tick();
      checks++;
      if (req_idx.size() - n0 != 5) begin
         errors++;
         $display("FAIL timeout_reqs: got %0d want 5", req_idx.size() - n0);
      end else begin
         checks++;
         if (err_cyc - req_cyc[n0+2] != 17) begin
            errors++;
            $display("FAIL timeout_when: got +%0d want +17",
                     err_cyc - req_cyc[n0+2]);
         end
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (cnt_v[k] !== exp[k]) begin
            errors++;
            $display("FAIL timeout_cnt%0d: got %0d want %0d", k, cnt_v[k], exp[k]);
         end
      end
      checks++;
      if (total !== 8'd35 || error !== 1'b1) begin
         errors++;
         $display("FAIL timeout_total: got %0d err %b want 35 1", total, error);
      end
      resp_mask = 5'b11111;
   endtask

   task automatic test_spurious();
      int s, d, n0, dc0;
      logic [4:0] exp [5];
      logic [4:0] old [5];
      old = '{5'd3, 5'd0, 5'd0, 5'd31, 5'd1};
      exp = '{5'd10, 5'd20, 5'd5, 5'd2, 5'd0};
      mem = exp;
      spur_idle = 1'b1;
      repeat (3) tick();
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (cnt_v[k] !== old[k]) begin
            errors++;
            $display("FAIL idle_valid_cnt%0d: got %0d want %0d",
                     k, cnt_v[k], old[k]);
         end
      end
      checks++;
      if (total !== 8'd35 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_valid_total: got %0d busy %b want 35 0", total, busy);
      end
      n0 = req_idx.size();
      dc0 = done_count;
      spur_issue = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      spur_idle = 1'b0;
      s = cyc;
      checks++;
      if (total !== 8'd0 || error !== 1'b0 || busy !== 1'b1 || req !== 1'b1) begin
         errors++;
         $display("FAIL accept_clear: got tot %0d err %b busy %b req %b want 0 0 1 1",
                  total, error, busy, req);
      end
      d = -1;
      for (int i = 0; i < 200; i++) begin
         if (done === 1'b1) begin
            d = cyc;
            break;
         end
         start = (i == 4);
         tick();
      end
      start = 1'b0;
      checks++;
      if (d - s != 15) begin
         errors++;
         $display("FAIL spur_latency: got %0d want 15", d - s);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      spur_issue = 1'b0;
      repeat (4) tick();
      checks++;
      if (req_idx.size() - n0 != 5 || busy !== 1'b0) begin
         errors++;
         $display("FAIL spur_reqs: got %0d reqs busy %b want 5 0",
                  req_idx.size() - n0, busy);
      end
      checks++;
      if (done_count - dc0 != 1) begin
         errors++;
         $display("FAIL spur_done_count: got %0d want 1", done_count - dc0);
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (cnt_v[k] !== exp[k]) begin
            errors++;
            $display("FAIL spur_cnt%0d: got %0d want %0d", k, cnt_v[k], exp[k]);
         end
      end
      checks++;
      if (total !== 8'd37) begin
         errors++;
         $display("FAIL spur_total: got %0d want 37", total);
      end
   endtask

   task automatic test_reset_mid();
      int s, d, dc0;
      bit seen;
      logic [4:0] exp [5];
      exp = '{5'd3, 5'd0, 5'd7, 5'd31, 5'd1};
      mem = exp;
      dc0 = done_count;
      seen = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (req === 1'b1 && idx === 3'd3) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL mid_reach_idx3: got none want req at idx 3");
      end
      tick();
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if ({req, busy, done, error} !== 4'b0 || idx !== 3'd0 || total !== 8'd0) begin
         errors++;
         $display("FAIL mid_async: got %b idx %0d tot %0d want 0000 0 0",
                  {req, busy, done, error}, idx, total);
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (cnt_v[k] !== 5'd0) begin
            errors++;
            $display("FAIL mid_cnt%0d: got %0d want 0", k, cnt_v[k]);
         end
      end
      tick();
      reset = 1'b0;
      repeat (3) tick();
      checks++;
      if (done_count != dc0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_no_done: got %0d done busy %b want 0 0",
                  done_count - dc0, busy);
      end
      run_sweep(s, d);
      checks++;
      if (d - s != 15) begin
         errors++;
         $display("FAIL mid_restart_latency: got %0d want 15", d - s);
      end
      tick();
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (cnt_v[k] !== exp[k]) begin
            errors++;
            $display("FAIL mid_restart_cnt%0d: got %0d want %0d",
                     k, cnt_v[k], exp[k]);
         end
      end
      checks++;
      if (total !== 8'd42 || error !== 1'b0) begin
         errors++;
         $display("FAIL mid_restart_total: got %0d err %b want 42 0", total, error);
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      mem = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
      test_reset();
      test_normal();
      test_slow();
      test_timeout();
      test_spurious();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lector_contador.md
Name: lector_contador

Overview:
- Requester side of the FIFO push-counter read interface (req/idx out, data/valid in).
- On a start pulse, sweeps idx 0..NUM_FIFOS-1 and issues one req per index.
- Captures each returned count into a result register and accumulates a total.
- Flags any index whose valid never arrives. Sits beside the probador in the counter bench and later in the top-level as the counter poller.

Parameters:
NUM_FIFOS, 5, number of counters swept (idx 0..NUM_FIFOS-1)
CNT_W, 5, width of each count / data bus
IDX_W, 3, width of idx
TOT_W, 8, width of total (must hold NUM_FIFOS*(2^CNT_W-1); 155 fits)
TIMEOUT, 15, max cycles waited for valid after a req

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a sweep when idle
data  input  CNT_W  count returned by the counter block
valid  input  1  qualifies data
req  output  1  read request to the counter block, one-cycle pulse per index
idx  output  IDX_W  counter index being requested
cnt0..cnt4  output  CNT_W each  captured count per FIFO
total  output  TOT_W  sum of cnt0..cnt4 for the last sweep
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when a sweep completes
error  output  1  sticky; set if any index timed out during the sweep

Behaviour:
- Reset (async, active-high): state IDLE; req=0, idx=0, cnt0..cnt4=0, total=0, busy=0, done=0, error=0, timeout counter=0. Reset mid-sweep aborts immediately. No done pulse. Results are cleared.
- FSM states: IDLE, ISSUE, WAIT, NEXT, DONE.
- IDLE:
  - start=1 at edge N -> ISSUE at N.
  - On accept: total cleared, error cleared, idx=0, busy=1.
  - cnt registers hold their previous values until overwritten.
- ISSUE: req=1 for exactly one cycle with the current idx. Next state is WAIT. Timeout counter loaded to 0.
- WAIT: req=0; idx held stable.
  - valid=1: data goes to cnt[idx]; total+=data (zero-extended); next state is NEXT.
  - No valid and timer reaches TIMEOUT: cnt[idx]=0, error=1, next state is NEXT.
  - Otherwise timer increments.
- NEXT:
  - idx==NUM_FIFOS-1: go to DONE.
  - Otherwise idx+1 and go to ISSUE.
- DONE: done=1 for one cycle; busy drops in the same cycle; return to IDLE. idx is left at NUM_FIFOS-1.
- Latency: with valid arriving the cycle after req, each index takes 3 cycles (ISSUE, WAIT, NEXT). Full sweep: done is high 16 cycles after the start edge.
- valid seen in IDLE, ISSUE, NEXT or DONE is ignored and must not change any result.
- valid in the same cycle as req (ISSUE) is ignored; only WAIT captures.
- start while busy is ignored, with no restart.
- start in the DONE cycle is ignored. A new sweep needs start in IDLE.
- total never wraps for legal data. Arithmetic is unsigned.

Decomposition:
- Shared package contador_pkg: FSM state encoding (IDLE..DONE), NUM_FIFOS/CNT_W/IDX_W defaults, TIMEOUT default. The counter block and the probador share these.
- No sub-module required. The timeout counter stays inline.
- Result registers form a CNT_W-wide array, exposed as cnt0..cnt4.

Test Plan:
- Reset then idle: assert reset mid-run -> all outputs 0 asynchronously. start with no reset -> req pulses at idx 0,1,2,3,4, one each.
- Normal sweep: counter preloaded to 3,0,7,31,1 with valid 1 cycle after req -> cnt0..4 = 3,0,7,31,1; total=42; done pulse 16 cycles after start; error=0.
- Slow responder: valid returned 4 cycles after each req -> same counts captured. idx stable while waiting. done pulse at start+31.
- Timeout: no valid for idx 2 -> cnt2=0, error=1 after TIMEOUT+1 wait cycles; sweep continues; total excludes idx 2.
- Spurious valid and start: valid=1 with data=9 in IDLE and ISSUE, plus start pulsed mid-sweep -> no result change, no restart, exactly 5 req pulses.
- Reset mid-sweep at idx 3 -> busy=0, cnt all 0, no done pulse. A fresh start then completes a normal sweep.
